// File: rtl/reg_master.sv
// ----------------------------------------------------------------------------
// reg_master
//   Bus master for a two-register target. Commands arrive on a valid/ready
//   interface, are buffered in a small FIFO and issued in order, at most one
//   bus operation per cycle, through a registered output stage. Read data
//   returned by the target is captured and presented with its address on a
//   valid/ready response interface. At most one read is ever outstanding, so a
//   response can never be overwritten before it is consumed.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready = FIFO not full)
//   cmd_write/cmd_addr/cmd_wdata  command: 1 = write, 0 = read
//   reg_op/reg_addr/reg_wdata     target bus (00 NOP, 01 RD, 10 WR)
//   reg_rdata                     target read data, valid the cycle after RD
//   rsp_valid/rsp_ready           read response handshake
//   rsp_addr/rsp_data             address and data of the returned read
// ----------------------------------------------------------------------------
module reg_master #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic [1:0]        reg_op,
    output logic [AWIDTH-1:0] reg_addr,
    output logic [DWIDTH-1:0] reg_wdata,
    input  logic [DWIDTH-1:0] reg_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [AWIDTH-1:0] rsp_addr,
    output logic [DWIDTH-1:0] rsp_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 1 + AWIDTH + DWIDTH;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    // ------------------------------------------------------------------
    // Command FIFO: entry = {write, addr, wdata}
    // ------------------------------------------------------------------
    logic [EW-1:0]     fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic [EW-1:0]     head_entry;
    logic              head_write;
    logic [AWIDTH-1:0] head_addr;
    logic [DWIDTH-1:0] head_wdata;

    // ------------------------------------------------------------------
    // Issue stage and read tracking
    // ------------------------------------------------------------------
    logic [1:0]        reg_op_reg;
    logic [AWIDTH-1:0] reg_addr_reg;
    logic [DWIDTH-1:0] reg_wdata_reg;
    logic [AWIDTH-1:0] rd_addr_reg;
    // p1_reg: high while the RD is on the bus (cycle N).
    // p2_reg: high in cycle N+1, when reg_rdata holds the read result.
    logic              p1_reg;
    logic              p2_reg;
    logic              read_ok;
    logic              issue;

    logic              rsp_valid_reg;
    logic [AWIDTH-1:0] rsp_addr_reg;
    logic [DWIDTH-1:0] rsp_data_reg;

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = issue;

    assign head_entry = fifo_mem[rd_ptr_reg];
    assign head_write = head_entry[EW-1];
    assign head_addr  = head_entry[EW-2 -: AWIDTH];
    assign head_wdata = head_entry[DWIDTH-1:0];

    // A read may only go out when nothing is in flight and the response
    // register is free (or is being emptied this very cycle).
    assign read_ok = !p1_reg && !p2_reg && (!rsp_valid_reg || rsp_ready);
    // Writes never wait; a blocked read at the head stalls everything behind it.
    assign issue   = !empty && (head_write || read_ok);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Registered bus stage; address and write data hold across NOP cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_op_reg    <= OP_NOP;
            reg_addr_reg  <= '0;
            reg_wdata_reg <= '0;
            rd_addr_reg   <= '0;
            p1_reg        <= 1'b0;
            p2_reg        <= 1'b0;
        end else begin
            if (issue) begin
                reg_op_reg    <= head_write ? OP_WR : OP_RD;
                reg_addr_reg  <= head_addr;
                reg_wdata_reg <= head_wdata;
            end else begin
                reg_op_reg    <= OP_NOP;
            end
            // The read address is kept separately because a write issued
            // right behind the read changes reg_addr before capture.
            if (issue && !head_write) begin
                rd_addr_reg <= head_addr;
            end
            p1_reg <= issue && !head_write;
            p2_reg <= p1_reg;
        end
    end

    // Response register: capture wins over a consumer accept on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_addr_reg  <= '0;
            rsp_data_reg  <= '0;
        end else if (p2_reg) begin
            rsp_valid_reg <= 1'b1;
            rsp_addr_reg  <= rd_addr_reg;
            rsp_data_reg  <= reg_rdata;
        end else if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign reg_op    = reg_op_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_wdata = reg_wdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_addr  = rsp_addr_reg;
    assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_reg_master.sv
// ----------------------------------------------------------------------------
// tb_reg_master
//   Self-checking bench for reg_master with a behavioural two-register target
//   (addresses 0 and 1, registered read data, unmapped reads leave reg_rdata
//   unchanged). A per-cycle vector table covers write/read-back and response
//   backpressure; hand-written sequences cover reset, FIFO full/drain with
//   response spacing, and reset during a read.
// ----------------------------------------------------------------------------
module tb_reg_master;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] RD  = 2'b01;
    localparam logic [1:0] WR  = 2'b10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [1:0]    reg_op;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [DW-1:0] reg_rdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_master #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .reg_op    (reg_op),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data)
    );

    // Behavioural target: not affected by the master's reset.
    logic [DW-1:0] tgt_regs [2] = '{8'h00, 8'h00};
    always @(posedge clk) begin
        if (reg_op == WR && reg_addr < 2) tgt_regs[reg_addr[0]] <= reg_wdata;
        if (reg_op == RD && reg_addr < 2) reg_rdata <= tgt_regs[reg_addr[0]];
    end

    typedef struct {
        logic          cv;
        logic          cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          rr;
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          rv;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t vt [21];

    function automatic vec_t v(input logic cv, input logic cw, input logic [7:0] ca,
                               input logic [7:0] cd, input logic rr, input logic [1:0] op,
                               input logic [7:0] addr, input logic [7:0] wd, input logic rv,
                               input logic [7:0] ra, input logic [7:0] rd);
        vec_t r;
        r.cv = cv; r.cw = cw; r.ca = ca; r.cd = cd; r.rr = rr;
        r.op = op; r.addr = addr; r.wd = wd; r.rv = rv; r.ra = ra; r.rd = rd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cv, input logic cw, input logic [7:0] ca, input logic [7:0] cd);
        cmd_valid = cv;
        cmd_write = cw;
        cmd_addr  = ca;
        cmd_wdata = cd;
    endtask

    logic [AW-1:0] push_addrs [DEPTH+2];
    logic [AW-1:0] exp_ra [DEPTH+1];
    logic [DW-1:0] exp_rd [DEPTH+1];
    logic [AW-1:0] got_ra [8];
    logic [DW-1:0] got_rd [8];
    int            got_t  [8];

    initial begin
        // ---------------- vector table ----------------
        // cv cw  ca     cd     rr | op   addr   wd     rv ra     rd
        vt[0]  = v(1, 1, 8'h00, 8'hA5, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        vt[1]  = v(1, 1, 8'h01, 8'h3C, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        vt[2]  = v(1, 0, 8'h00, 8'h00, 1, WR,  8'h00, 8'hA5, 0, 8'h00, 8'h00);
        vt[3]  = v(1, 0, 8'h01, 8'h00, 1, WR,  8'h01, 8'h3C, 0, 8'h00, 8'h00);
        vt[4]  = v(0, 0, 8'h00, 8'h00, 1, RD,  8'h00, 8'h00, 0, 8'h00, 8'h00);
        vt[5]  = v(0, 0, 8'h00, 8'h00, 1, NOP, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        vt[6]  = v(0, 0, 8'h00, 8'h00, 1, NOP, 8'h00, 8'h00, 1, 8'h00, 8'hA5);
        vt[7]  = v(0, 0, 8'h00, 8'h00, 1, RD,  8'h01, 8'h00, 0, 8'h00, 8'h00);
        vt[8]  = v(0, 0, 8'h00, 8'h00, 1, NOP, 8'h01, 8'h00, 0, 8'h00, 8'h00);
        vt[9]  = v(0, 0, 8'h00, 8'h00, 1, NOP, 8'h01, 8'h00, 1, 8'h01, 8'h3C);
        // backpressure: RD 00 then WR 01<=11 then a blocked RD 01
        vt[10] = v(1, 0, 8'h00, 8'h00, 0, NOP, 8'h01, 8'h00, 0, 8'h00, 8'h00);
        vt[11] = v(1, 1, 8'h01, 8'h11, 0, NOP, 8'h01, 8'h00, 0, 8'h00, 8'h00);
        vt[12] = v(1, 0, 8'h01, 8'h00, 0, RD,  8'h00, 8'h00, 0, 8'h00, 8'h00);
        vt[13] = v(0, 0, 8'h00, 8'h00, 0, WR,  8'h01, 8'h11, 0, 8'h00, 8'h00);
        vt[14] = v(0, 0, 8'h00, 8'h00, 0, NOP, 8'h01, 8'h00, 1, 8'h00, 8'hA5);
        vt[15] = v(0, 0, 8'h00, 8'h00, 0, NOP, 8'h01, 8'h00, 1, 8'h00, 8'hA5);
        vt[16] = v(0, 0, 8'h00, 8'h00, 1, NOP, 8'h01, 8'h00, 1, 8'h00, 8'hA5);
        vt[17] = v(0, 0, 8'h00, 8'h00, 1, RD,  8'h01, 8'h00, 0, 8'h00, 8'h00);
        vt[18] = v(0, 0, 8'h00, 8'h00, 1, NOP, 8'h01, 8'h00, 0, 8'h00, 8'h00);
        vt[19] = v(0, 0, 8'h00, 8'h00, 1, NOP, 8'h01, 8'h00, 1, 8'h01, 8'h11);
        vt[20] = v(0, 0, 8'h00, 8'h00, 1, NOP, 8'h01, 8'h00, 0, 8'h00, 8'h00);

        // ---------------- reset then idle ----------------
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_op", reg_op, NOP);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_addr_wdata", {reg_addr, reg_wdata}, 16'h0000);
        chk("reset_rsp_addr_data", {rsp_addr, rsp_data}, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_no_activity", {reg_op, rsp_valid, cmd_ready}, {NOP, 1'b0, 1'b1});
        end

        // ---------------- table-driven write/read-back and backpressure ----
        for (int i = 0; i < 21; i++) begin
            tick();
            drive(vt[i].cv, vt[i].cw, vt[i].ca, vt[i].cd);
            rsp_ready = vt[i].rr;
            @(negedge clk);
            $display("[TB] vec %0d op=%0d addr=%02h rsp_valid=%0b rsp=(%02h,%02h)",
                     i, reg_op, reg_addr, rsp_valid, rsp_addr, rsp_data);
            chk($sformatf("vec%0d_op", i), reg_op, vt[i].op);
            chk($sformatf("vec%0d_addr", i), reg_addr, vt[i].addr);
            if (vt[i].op == WR) chk($sformatf("vec%0d_wdata", i), reg_wdata, vt[i].wd);
            chk($sformatf("vec%0d_cmd_ready", i), cmd_ready, 1);
            chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, vt[i].rv);
            if (vt[i].rv) chk($sformatf("vec%0d_rsp", i), {rsp_addr, rsp_data}, {vt[i].ra, vt[i].rd});
        end

        // ---------------- FIFO full with one read outstanding ----------------
        // Target now holds reg0=A5, reg1=11. Address 5 is unmapped: it must
        // return the stale value left by the preceding read of address 1.
        push_addrs = '{8'h00, 8'h01, 8'h05, 8'h00, 8'h01, 8'h00};
        exp_ra = '{8'h00, 8'h00, 8'h01, 8'h05, 8'h00};
        exp_rd = '{8'hA5, 8'hA5, 8'h11, 8'h11, 8'hA5};
        tick();
        rsp_ready = 1'b0;
        drive(1, 0, 8'h00, 8'h00);
        tick();
        drive(0, 0, 8'h00, 8'h00);
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1;
                else tick();
            end
            chk("full_first_rsp_timeout", seen, 1);
        end
        begin
            int j = 0;
            for (int k = 0; k < DEPTH + 2; k++) begin
                tick();
                drive(1, 0, push_addrs[j], 8'h00);
                @(negedge clk);
                chk("full_rsp_stable", {rsp_valid, rsp_addr, rsp_data}, {1'b1, 8'h00, 8'hA5});
                chk("full_no_rd_on_bus", reg_op == RD, 0);
                if (cmd_ready) j++;
            end
            tick();
            drive(0, 0, 8'h00, 8'h00);
            @(negedge clk);
            chk("full_accepted_count", j, DEPTH);
            chk("full_cmd_ready_low", cmd_ready, 0);
        end

        // ---------------- drain: spacing of back-to-back reads ----------------
        tick();
        rsp_ready = 1'b1;
        begin
            int n = 0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    if (n < 8) begin
                        got_ra[n] = rsp_addr;
                        got_rd[n] = rsp_data;
                        got_t[n]  = c;
                    end
                    $display("[TB] drain rsp %0d addr=%02h data=%02h cycle=%0d", n, rsp_addr, rsp_data, c);
                    n++;
                end
                tick();
            end
            chk("drain_rsp_count", n, DEPTH + 1);
            for (int i = 0; i < DEPTH + 1 && i < n; i++) begin
                chk($sformatf("drain_rsp%0d", i), {got_ra[i], got_rd[i]}, {exp_ra[i], exp_rd[i]});
                if (i > 0) chk($sformatf("drain_spacing%0d", i), got_t[i] - got_t[i-1], 3);
            end
            chk("drain_cmd_ready", cmd_ready, 1);
        end

        // ---------------- reset during a read ----------------
        drive(1, 0, 8'h01, 8'h00);
        tick();
        drive(1, 0, 8'h00, 8'h00);   // stays queued behind the in-flight read
        tick();
        drive(0, 0, 8'h00, 8'h00);
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (reg_op == RD) seen = 1;
                else tick();
            end
            chk("rstmid_rd_seen", seen, 1);
            chk("rstmid_rd_addr", reg_addr, 8'h01);
        end
        tick();
        rst = 1'b1;                  // cycle N+1 of the read
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rstmid_quiet", {reg_op, rsp_valid, cmd_ready}, {NOP, 1'b0, 1'b1});
            tick();
        end
        drive(1, 0, 8'h01, 8'h00);
        tick();
        drive(0, 0, 8'h00, 8'h00);
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    seen = 1;
                    $display("[TB] post-reset rsp addr=%02h data=%02h", rsp_addr, rsp_data);
                    chk("rstmid_readback", {rsp_addr, rsp_data}, {8'h01, 8'h11});
                end else begin
                    tick();
                end
            end
            chk("rstmid_rsp_timeout", seen, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
